// File: rtl/ram_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single-port data RAM with READ_LAT-cycle read latency.
// Optional debug starvation guard is built only when ARB_STARVE_GUARD_EN is defined.
module ram_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_gnt,
    output logic       dbg_rvalid,
    output logic [7:0] dbg_rdata,
    input  logic       cpu_paused,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [2:0] LAT_C     = 3'(READ_LAT);

    if (READ_LAT < 1 || READ_LAT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("ram_arbiter: READ_LAT or STARVE_LIMIT out of legal range");
    end

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;          // 1 = debug owns the in-flight access
    logic       we_q, we_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       cpu_gnt_q, cpu_gnt_d;
    logic       dbg_gnt_q, dbg_gnt_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       dbg_rvalid_q, dbg_rvalid_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] dbg_rdata_q, dbg_rdata_d;
    logic       starve_hit_s;
    logic       dbg_wins_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Count contested IDLE arbitrations that debug loses; any debug win clears the count.
    always_comb begin
        starve_hit_s = (starve_cnt_q >= STARVE_C);
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE && dbg_req) begin
            if (dbg_wins_s) begin
                starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != 4'hF) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_hit_s = 1'b0;
`endif

    // Debug wins when alone, when the CPU is paused, or when the starvation guard fires.
    assign dbg_wins_s = dbg_req & (~cpu_req | cpu_paused | starve_hit_s);

    // Access sequencer: arbitrate and latch in IDLE, drive the RAM in ACCESS, wait out read latency.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d     = dbg_wins_s;
                    we_d        = dbg_wins_s ? dbg_we    : cpu_we;
                    mem_addr_d  = dbg_wins_s ? dbg_addr  : cpu_addr;
                    mem_wdata_d = dbg_wins_s ? dbg_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dbg_wins_s ? dbg_we : cpu_we;
                    cpu_gnt_d   = ~dbg_wins_s;
                    dbg_gnt_d   = dbg_wins_s;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = 3'd1;
                    state_d   = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (lat_cnt_q >= LAT_C) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        dbg_rdata_d  = mem_rdata;
                        dbg_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            lat_cnt_q    <= 3'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'h00;
            mem_wdata_q  <= 8'h00;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            dbg_rdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
